// File: rtl/ram_sync_2p_if.sv
// ram_sync_2p port bundle: write, read, clear and status.
// With RAM_PARITY_EN the bundle also carries pinj / perr.
interface ram_sync_2p_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             clr;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] d;
  logic             re;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
`ifdef RAM_PARITY_EN
  logic             pinj;
  logic             perr;
`endif

  modport master (
    output clr, we, wa, d, re, ra,
`ifdef RAM_PARITY_EN
    output pinj,
    input  perr,
`endif
    input  q, q_valid, busy
  );

  modport slave (
    input  clr, we, wa, d, re, ra,
`ifdef RAM_PARITY_EN
    input  pinj,
    output perr,
`endif
    output q, q_valid, busy
  );
endinterface

// File: rtl/ram_sync_2p.sv
// Simple dual-port RAM, write-first forwarding, clear sequencer.
// Optional per-word even parity: define RAM_PARITY_EN.
module ram_sync_2p #(
  parameter int               WIDTH = 8,
  parameter int               AW    = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input logic         wclk,
  input logic         rst,
  ram_sync_2p_if.slave bus
);

  localparam int DEPTH = 1 << AW;
`ifdef RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = WIDTH + PW;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [MW-1:0]    mem [DEPTH];

  logic [WIDTH-1:0] q_r;
  logic             qv_r;
  logic             perr_r;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [MW-1:0]    mem_wd;
  logic [MW-1:0]    init_w;
  logic [MW-1:0]    wr_w;
  logic [MW-1:0]    rd_w;
  logic             fwd;
  logic             acc;

`ifdef RAM_PARITY_EN
  assign init_w = {^INIT, INIT};
  assign wr_w   = {(^bus.d) ^ bus.pinj, bus.d};
`else
  assign init_w = INIT;
  assign wr_w   = bus.d;
`endif

  assign rd_w = mem[bus.ra];
  assign fwd  = bus.we && (bus.wa == bus.ra);
  assign acc  = (state == IDLE) && !bus.clr;

  // rst forces busy before the first reset edge has settled state
  assign bus.busy    = rst || (state == CLEAR);
  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
`ifdef RAM_PARITY_EN
  assign bus.perr    = perr_r;
`endif

  // select the single memory write: sweep word or user write
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt;
    mem_wd = init_w;
    if (!rst) begin
      unique case (state)
        CLEAR: mem_we = !bus.clr;
        IDLE: begin
          if (acc && bus.we) begin
            mem_we = 1'b1;
            mem_wa = bus.wa;
            mem_wd = wr_w;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // storage array, never reset directly
  always_ff @(posedge wclk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // control FSM and registered read port
  always_ff @(posedge wclk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      q_r    <= '0;
      qv_r   <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          qv_r   <= 1'b0;
          perr_r <= 1'b0;
          if (bus.clr) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == {AW{1'b1}}) begin
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (bus.clr) begin
            state  <= CLEAR;
            cnt    <= '0;
            qv_r   <= 1'b0;
            perr_r <= 1'b0;
          end else if (bus.re) begin
            qv_r <= 1'b1;
            if (fwd) begin
              q_r <= bus.d;
`ifdef RAM_PARITY_EN
              perr_r <= bus.pinj;
`else
              perr_r <= 1'b0;
`endif
            end else begin
              q_r    <= rd_w[WIDTH-1:0];
              perr_r <= (PW != 0) && (^rd_w);
            end
          end else begin
            qv_r   <= 1'b0;
            perr_r <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_2p.sv
// Scoreboard bench for ram_sync_2p (WIDTH=8, AW=4, INIT=A5).
// Expected reads are queued at issue and checked by a monitor.
module tb_ram_sync_2p;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic wclk = 1'b0;
  logic rst  = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;
  exp_t sb[$];

  ram_sync_2p_if #(.WIDTH(8), .AW(4)) bus ();

  ram_sync_2p #(
    .WIDTH(8),
    .AW   (4),
    .INIT (8'hA5)
  ) dut (
    .wclk(wclk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] dv, input logic pv);
    exp_t e;
    e.d = dv;
    e.p = pv;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wr(input int a, input int dv, input logic pj);
    bus.we = 1'b1;
    bus.wa = 4'(a);
    bus.d  = 8'(dv);
`ifdef RAM_PARITY_EN
    bus.pinj = pj;
`endif
    tick();
    bus.we = 1'b0;
`ifdef RAM_PARITY_EN
    bus.pinj = 1'b0;
`endif
  endtask

  task automatic rd(input int a, input int dv, input logic pv);
    bus.re = 1'b1;
    bus.ra = 4'(a);
    push(8'(dv), pv);
    tick();
    bus.re = 1'b0;
  endtask

  // monitor: every valid read result pops one expectation
  always @(negedge wclk) begin
    if (bus.q_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: got %0h want none", bus.q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.q !== e.d) begin
          fails++;
          $display("FAIL read_q: got %0h want %0h", bus.q, e.d);
        end
`ifdef RAM_PARITY_EN
        tests++;
        if (bus.perr !== e.p) begin
          fails++;
          $display("FAIL read_perr: got %0b want %0b", bus.perr, e.p);
        end
`endif
      end
    end
  end

  initial begin
    bus.clr = 1'b0;
    bus.we  = 1'b0;
    bus.wa  = '0;
    bus.d   = '0;
    bus.re  = 1'b0;
    bus.ra  = '0;
`ifdef RAM_PARITY_EN
    bus.pinj = 1'b0;
`endif

    // reset, then the 16-cycle sweep
    repeat (3) tick();
    chk("rst_q", int'(bus.q), 0);
    chk("rst_qv", int'(bus.q_valid), 0);
    chk("rst_busy", int'(bus.busy), 1);
    rst = 1'b0;
    wait_idle();
    chk("clear_len", n, 16);

    // init contents, back-to-back
    for (int a = 0; a < 16; a++) begin
      bus.re = 1'b1;
      bus.ra = 4'(a);
      push(8'hA5, 1'b0);
      tick();
      chk("qv_cont_init", int'(bus.q_valid), 1);
    end
    bus.re = 1'b0;
    tick();
    chk("qv_drop", int'(bus.q_valid), 0);

    // pattern a*3, then streamed readback
    for (int a = 0; a < 16; a++) wr(a, a * 3, 1'b0);
    for (int a = 0; a < 16; a++) begin
      bus.re = 1'b1;
      bus.ra = 4'(a);
      push(8'(a * 3), 1'b0);
      tick();
      chk("qv_cont_pat", int'(bus.q_valid), 1);
    end
    bus.re = 1'b0;
    tick();

    // write-first forwarding on addr 7
    wr(7, 8'h11, 1'b0);
    bus.we = 1'b1;
    bus.wa = 4'd7;
    bus.d  = 8'h22;
    rd(7, 8'h22, 1'b0);
    bus.we = 1'b0;
    rd(7, 8'h22, 1'b0);
    tick();

    // clr mid-operation, accesses during busy dropped
    wr(3, 8'hFF, 1'b0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_busy", int'(bus.busy), 1);
    bus.we = 1'b1;
    bus.wa = 4'd5;
    bus.d  = 8'h77;
    bus.re = 1'b1;
    bus.ra = 4'd3;
    tick();
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("busy_qv", int'(bus.q_valid), 0);
    wait_idle();
    chk("clr_len", n + 1, 16);
    rd(3, 8'hA5, 1'b0);
    rd(5, 8'hA5, 1'b0);
    tick();

    // reset at cnt=9 restarts the sweep
    chk("pre_rst_q", int'(bus.q), 8'hA5);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst9_q", int'(bus.q), 0);
    chk("rst9_qv", int'(bus.q_valid), 0);
    wait_idle();
    chk("rst9_len", n, 16);
    rd(9, 8'hA5, 1'b0);
    rd(15, 8'hA5, 1'b0);

`ifdef RAM_PARITY_EN
    // parity injection, detection and scrub by clear
    wr(2, 8'h3C, 1'b1);
    wr(4, 8'h3C, 1'b0);
    rd(2, 8'h3C, 1'b1);
    rd(4, 8'h3C, 1'b0);
    bus.we   = 1'b1;
    bus.wa   = 4'd6;
    bus.d    = 8'h01;
    bus.pinj = 1'b1;
    rd(6, 8'h01, 1'b1);
    bus.we   = 1'b0;
    bus.pinj = 1'b0;
    bus.clr  = 1'b1;
    tick();
    bus.clr  = 1'b0;
    wait_idle();
    rd(2, 8'hA5, 1'b0);
`endif

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
